// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
// The top module adds the WIDTH % STAGES legality check; cfg_legal supplies the rule.
package pipe_adder_pkg;

  localparam int unsigned MAX_CW = 64;

  // One pipeline slot's handshake view: valid, its sum chunk and the chunk carry-out.
  typedef struct packed {
    logic              valid;
    logic [MAX_CW-1:0] sum;
    logic              carry;
  } stage_t;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit cfg_legal(input int unsigned width,
                                   input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CW-bit chunk of the ripple pipeline: registers sum chunk, carry-out and valid.
module adder_stage #(
  parameter int unsigned CW      = 8,
  parameter bit          COUT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          vin,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          vout
);

  localparam int unsigned FW = CW + 1;

  logic [CW-1:0] sum_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout <= 1'b0;
      sum  <= '0;
    end else if (advance) begin
      vout <= vin;
      sum  <= sum_c;
    end
  end

  // The carry register is only built where something downstream consumes it.
  if (COUT_EN) begin : g_cout
    logic [CW:0] full_c;
    assign full_c = {1'b0, a} + {1'b0, b} + FW'(cin);
    assign sum_c  = full_c[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cout <= 1'b0;
      else if (advance) cout <= full_c[CW];
    end
  end else begin : g_nocout
    assign sum_c = a + b + CW'(cin);
    assign cout  = 1'b0;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor with one carry-ripple chunk per stage.
// Define PIPE_ADDER_FLAGS_EN to build the carry/overflow/zero flag outputs.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_x;

  // Whole pipeline moves together; bubbles are held, never collapsed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_x      = in_b ^ {WIDTH{in_sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned LO = k * CW;
    localparam int unsigned AW = WIDTH - LO;
    localparam int unsigned HI = AW - CW;

    logic [AW-1:0]    a_in;
    logic [AW-1:0]    b_in;
    logic             cin;
    logic             vin;
    logic [CW-1:0]    s;
    logic             c;
    logic             v;
    logic [LO+CW-1:0] sum;

    if (k == 0) begin : g_head
      assign a_in = in_a;
      assign b_in = b_x;
      assign cin  = in_sub;
      assign vin  = in_valid;
      assign sum  = s;
    end else begin : g_body
      logic [LO-1:0] lo_q;

      // De-skew: lower result chunks wait here for the upper chunks to catch up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lo_q <= '0;
        else if (advance) lo_q <= g_st[k-1].sum;
      end

      assign a_in = g_st[k-1].g_skew.a_hi_q;
      assign b_in = g_st[k-1].g_skew.b_hi_q;
      assign cin  = g_st[k-1].c;
      assign vin  = g_st[k-1].v;
      assign sum  = {s, lo_q};
    end

    if (HI > 0) begin : g_skew
      logic [HI-1:0] a_hi_q;
      logic [HI-1:0] b_hi_q;

      // Skew: operand chunks not yet consumed travel alongside the transaction.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (advance) begin
          a_hi_q <= a_in[AW-1:CW];
          b_hi_q <= b_in[AW-1:CW];
        end
      end
    end

    adder_stage #(
      .CW      (CW),
      .COUT_EN ((k + 1 < STAGES) || FLAGS_EN)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .vin     (vin),
      .a       (a_in[CW-1:0]),
      .b       (b_in[CW-1:0]),
      .cin     (cin),
      .sum     (s),
      .cout    (c),
      .vout    (v)
    );
  end

  assign out_valid = g_st[STAGES-1].v;
  assign out_sum   = g_st[STAGES-1].sum;

`ifdef PIPE_ADDER_FLAGS_EN
  logic p_msb_q;

  // MSB propagate of the final chunk; with the sum MSB it recovers the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       p_msb_q <= 1'b0;
    else if (advance) p_msb_q <= g_st[STAGES-1].a_in[CW-1] ^ g_st[STAGES-1].b_in[CW-1];
  end

  assign out_carry = g_st[STAGES-1].c;
  assign out_ovf   = p_msb_q ^ out_sum[WIDTH-1] ^ out_carry;
  assign out_zero  = ~|out_sum;
`else
  logic unused_cout;
  assign unused_cout = g_st[STAGES-1].c;
  assign out_carry   = 1'b0;
  assign out_ovf     = 1'b0;
  assign out_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: four pipe_adder configurations driven in lock-step against an
// arithmetic reference model, with directed corners, reset, latency and stall checks.
module tb_pipe_adder;

  localparam int unsigned ND = 4;

`ifdef PIPE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, sub, out_ready;
  logic [63:0] a, b;
  logic        rdy  [ND];
  logic        ovld [ND];
  logic        oc   [ND];
  logic        oo   [ND];
  logic        oz   [ND];
  logic [63:0] osum [ND];
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [63:0] s3;

  assign osum[0] = 64'(s0);
  assign osum[1] = 64'(s1);
  assign osum[2] = 64'(s2);
  assign osum[3] = s3;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(a[31:0]), .in_b(b[31:0]), .in_sub(sub), .out_valid(ovld[0]),
    .out_ready(out_ready), .out_sum(s0), .out_carry(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]));
  pipe_adder #(.WIDTH(8), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(a[7:0]), .in_b(b[7:0]), .in_sub(sub), .out_valid(ovld[1]),
    .out_ready(out_ready), .out_sum(s1), .out_carry(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]));
  pipe_adder #(.WIDTH(16), .STAGES(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(a[15:0]), .in_b(b[15:0]), .in_sub(sub), .out_valid(ovld[2]),
    .out_ready(out_ready), .out_sum(s2), .out_carry(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]));
  pipe_adder #(.WIDTH(64), .STAGES(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_a(a), .in_b(b), .in_sub(sub), .out_valid(ovld[3]),
    .out_ready(out_ready), .out_sum(s3), .out_carry(oc[3]), .out_ovf(oo[3]), .out_zero(oz[3]));

  int          nvec = 0;
  int          nerr = 0;
  res_t        exp_q [ND][$];
  bit          hold_chk = 1'b0;
  logic [63:0] held;
  bit          acc0;
  bit          saw_drop;

  function automatic int unsigned wd(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned st(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  // Reference: modular add/subtract on masked operands, flags from their definitions.
  function automatic res_t model(input int unsigned w, input logic [63:0] aa, input logic [63:0] bb,
                                 input logic s);
    logic [64:0] m, am, bm, t;
    logic        sa, sb, sr;
    res_t        r;
    m  = (65'd1 << w) - 65'd1;
    am = {1'b0, aa} & m;
    bm = {1'b0, bb} & m;
    if (s) begin
      t   = (am - bm) & m;
      r.c = (am >= bm);
    end else begin
      t   = am + bm;
      r.c = t[w];
      t   = t & m;
    end
    sa    = am[w-1];
    sb    = bm[w-1];
    sr    = t[w-1];
    r.sum = t[63:0];
    r.v   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    r.z   = (t == 65'd0);
    if (!FLAGS) begin
      r.c = 1'b0;
      r.v = 1'b0;
      r.z = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0080;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock: check stall stability, score handshakes on every DUT, advance to next negedge.
  task automatic cycle();
    res_t e;
    #1;
    if (hold_chk) chk("d0_stall_stable_sum", osum[0], held);
    hold_chk = ovld[0] && !out_ready;
    held     = osum[0];
    acc0     = in_valid && rdy[0];
    if (ovld[0] && !out_ready && !rdy[0]) saw_drop = 1'b1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("d%0d_in_ready", i), 64'(rdy[i]), 64'(!ovld[i] || out_ready));
      if (in_valid && rdy[i]) exp_q[i].push_back(model(wd(i), a, b, sub));
      if (ovld[i] && out_ready) begin
        chk($sformatf("d%0d_result_expected", i), 64'(exp_q[i].size() != 0), 64'd1);
        if (exp_q[i].size() != 0) begin
          e = exp_q[i].pop_front();
          chk($sformatf("d%0d_sum", i), osum[i], e.sum);
          chk($sformatf("d%0d_carry", i), 64'(oc[i]), 64'(e.c));
          chk($sformatf("d%0d_ovf", i), 64'(oo[i]), 64'(e.v));
          chk($sformatf("d%0d_zero", i), 64'(oz[i]), 64'(e.z));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] aa, input logic [63:0] bb,
                       input logic s, input logic r);
    in_valid  = v;
    a         = aa;
    b         = bb;
    sub       = s;
    out_ready = r;
    cycle();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_d%0d_out_valid", tag, i), 64'(ovld[i]), 64'd0);
      chk($sformatf("%s_d%0d_out_sum", tag, i), osum[i], 64'd0);
      chk($sformatf("%s_d%0d_in_ready", tag, i), 64'(rdy[i]), 64'd1);
      chk($sformatf("%s_d%0d_zero", tag, i), 64'(oz[i]), 64'(FLAGS));
      chk($sformatf("%s_d%0d_carry_ovf", tag, i), 64'({oc[i], oo[i]}), 64'd0);
      exp_q[i].delete();
    end
    hold_chk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    end
    for (int i = 0; i < ND; i++)
      chk($sformatf("d%0d_drained", i), 64'(exp_q[i].size()), 64'd0);
  endtask

  initial begin
    logic [63:0] da [6];
    logic [63:0] db [6];
    logic        ds [6];
    int          lat [ND];
    logic [63:0] op_a, op_b;
    logic        op_s;
    int          sent;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    do_reset("por");

    // Reset with three adds in flight; nothing stale may surface afterwards.
    for (int n = 0; n < 3; n++) drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b1);
    in_valid = 1'b0;
    do_reset("mid");
    for (int n = 0; n < 10; n++) drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < ND; i++) chk($sformatf("post_rst_d%0d_idle", i), 64'(ovld[i]), 64'd0);

    // Directed corners: chunk carry, signed overflow, wrap to zero, borrow cases.
    da = '{64'h0000_FFFF, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 64'd5, 64'd7, 64'h8000_0000};
    db = '{64'h1,         64'h1,         64'h1,         64'd7, 64'd5, 64'h1};
    ds = '{1'b0,          1'b0,          1'b0,          1'b1,  1'b1,  1'b1};
    for (int n = 0; n < 6; n++) drive(1'b1, da[n], db[n], ds[n], 1'b1);
    drain();

    // Latency from presentation to out_valid with no stalls.
    drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < ND; i++) lat[i] = 0;
    for (int n = 1; n <= 12; n++) begin
      #1;
      for (int i = 0; i < ND; i++) if (lat[i] == 0 && ovld[i]) lat[i] = n;
      cycle();
    end
    for (int i = 0; i < ND; i++) chk($sformatf("d%0d_latency", i), 64'(lat[i]), 64'(st(i)));
    drain();

    // Backpressure: 10 ops held until accepted, consumer stalled for 5 cycles mid-stream.
    sent = 0; saw_drop = 1'b0;
    op_a = rnd_op(); op_b = rnd_op(); op_s = 1'($urandom);
    for (int cyc = 0; cyc < 40 && sent < 10; cyc++) begin
      drive(1'b1, op_a, op_b, op_s, !(cyc >= 4 && cyc < 9));
      if (acc0) begin
        sent++;
        op_a = rnd_op(); op_b = rnd_op(); op_s = 1'($urandom);
      end
    end
    chk("bp_ops_accepted", 64'(sent), 64'd10);
    chk("bp_in_ready_dropped", 64'(saw_drop), 64'd1);
    drain();

    // Random traffic with random valid gaps and consumer stalls on all configurations.
    for (int n = 0; n < 1400; n++) begin
      op_a = rnd_op();
      op_b = ($urandom_range(0, 7) == 0) ? op_a : rnd_op();
      drive($urandom_range(0, 99) < 85, op_a, op_b, 1'($urandom), $urandom_range(0, 99) < 75);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
